// File: rtl/vga_scan_ctrl_pkg.sv
// vga_scan_ctrl_pkg: raster geometry, bus widths and the raw-timing bundle shared by the scan controller
package vga_scan_ctrl_pkg;
    localparam int H_DISP_LEN      = 10;
    localparam int V_DISP_LEN      = 10;
    localparam int COLOR_RGB_DEPTH = 12;
    localparam int H_DISP  = 640;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_TOTAL = 800;
    localparam int V_DISP  = 480;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_TOTAL = 525;
    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
    } raster_t;
    localparam raster_t RASTER_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
endpackage

// File: rtl/vga_scan_ctrl_timing_gen.sv
// vga_timing_gen: 800x525 raster counters, raw act/hsync/vsync and the once-per-frame layer strobe
//   clk_vga/rst   pixel clock, sync active-high reset
//   h_nxt_o/v_nxt_o/act_nxt_o  counter values (and active flag) the next edge will load
//   raster_o      raw act/hs_n/vs_n of the current counter stage
//   v_sync_o      high while the counter stage sits at (0, V_ACT)
module vga_timing_gen
    import vga_scan_ctrl_pkg::*;
#(
    parameter int H_ACT = H_DISP,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_TOT = H_TOTAL,
    parameter int V_ACT = V_DISP,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_TOT = V_TOTAL
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    output logic [H_DISP_LEN-1:0] h_nxt_o,
    output logic [V_DISP_LEN-1:0] v_nxt_o,
    output logic                  act_nxt_o,
    output raster_t               raster_o,
    output logic                  v_sync_o
);
    localparam int HS_BEG = H_ACT + H_FP;
    localparam int HS_END = HS_BEG + H_SW;
    localparam int VS_BEG = V_ACT + V_FP;
    localparam int VS_END = VS_BEG + V_SW;
    logic [H_DISP_LEN-1:0] h_cnt_q;
    logic [V_DISP_LEN-1:0] v_cnt_q;
    logic                  h_wrap;
    function automatic raster_t raster_of(input logic [H_DISP_LEN-1:0] h, input logic [V_DISP_LEN-1:0] v);
        raster_t r;
        r.act  = (h < H_DISP_LEN'(H_ACT)) && (v < V_DISP_LEN'(V_ACT));
        r.hs_n = !((h >= H_DISP_LEN'(HS_BEG)) && (h < H_DISP_LEN'(HS_END)));
        r.vs_n = !((v >= V_DISP_LEN'(VS_BEG)) && (v < V_DISP_LEN'(VS_END)));
        return r;
    endfunction
    always_comb begin
        h_wrap    = h_cnt_q == H_DISP_LEN'(H_TOT - 1);
        h_nxt_o   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_nxt_o   = !h_wrap ? v_cnt_q : (v_cnt_q == V_DISP_LEN'(V_TOT - 1)) ? '0 : v_cnt_q + 1'b1;
        act_nxt_o = raster_of(h_nxt_o, v_nxt_o).act;
        raster_o  = raster_of(h_cnt_q, v_cnt_q);
    end
    // the strobe is registered from the next counter values so it lands in the same cycle as the counters
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            v_sync_o <= 1'b0;
        end else begin
            h_cnt_q  <= h_nxt_o;
            v_cnt_q  <= v_nxt_o;
            v_sync_o <= (h_nxt_o == '0) && (v_nxt_o == V_DISP_LEN'(V_ACT));
        end
    end
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: scans the raster, requests sprite-layer pixels, composites them by priority and flags collisions
//   clk_vga/rst/en_i            pixel clock, sync active-high reset, game running
//   req_x_addr_o/req_y_addr_o   requested pixel (0 outside the active area); v_sync_o frame strobe
//   *_alpha_i/*_rgb_i, bg_rgb_i layer responses RESP_LAT cycles after the request
//   crash_*_o                   combinational overlap strobes in the response cycle; me_hit_o sticky
//   hsync_o/vsync_o/rgb_o       VGA output, aligned one cycle after the response
module vga_scan_ctrl
    import vga_scan_ctrl_pkg::*;
#(
    parameter int RESP_LAT = 1,
    parameter int H_ACT    = H_DISP,
    parameter int H_FP     = H_FRONT,
    parameter int H_SW     = H_SYNC,
    parameter int H_TOT    = H_TOTAL,
    parameter int V_ACT    = V_DISP,
    parameter int V_FP     = V_FRONT,
    parameter int V_SW     = V_SYNC,
    parameter int V_TOT    = V_TOTAL
) (
    input  logic                       clk_vga,
    input  logic                       rst,
    input  logic                       en_i,
    output logic [H_DISP_LEN-1:0]      req_x_addr_o,
    output logic [V_DISP_LEN-1:0]      req_y_addr_o,
    output logic                       v_sync_o,
    input  logic                       me_alpha_i,
    input  logic [COLOR_RGB_DEPTH-1:0] me_rgb_i,
    input  logic                       bullet_alpha_i,
    input  logic [COLOR_RGB_DEPTH-1:0] bullet_rgb_i,
    input  logic                       enemy_alpha_i,
    input  logic [COLOR_RGB_DEPTH-1:0] enemy_rgb_i,
    input  logic [COLOR_RGB_DEPTH-1:0] bg_rgb_i,
    output logic                       crash_enemy_bullet_o,
    output logic                       crash_me_enemy_o,
    output logic                       me_hit_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic [COLOR_RGB_DEPTH-1:0] rgb_o
);
    logic [H_DISP_LEN-1:0]      h_nxt, req_x_q;
    logic [V_DISP_LEN-1:0]      v_nxt, req_y_q;
    logic                       act_nxt, act_r, hsync_q, vsync_q, me_hit_q;
    logic [COLOR_RGB_DEPTH-1:0] pix_d, rgb_q;
    raster_t                    raster;
    raster_t                    dl_q [RESP_LAT];
    vga_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_TOT(H_TOT),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_TOT(V_TOT)
    ) u_timing (
        .clk_vga  (clk_vga),
        .rst      (rst),
        .h_nxt_o  (h_nxt),
        .v_nxt_o  (v_nxt),
        .act_nxt_o(act_nxt),
        .raster_o (raster),
        .v_sync_o (v_sync_o)
    );
    always_comb begin
        act_r                = dl_q[RESP_LAT-1].act;
        crash_enemy_bullet_o = en_i & act_r & enemy_alpha_i & bullet_alpha_i;
        crash_me_enemy_o     = en_i & act_r & me_alpha_i & enemy_alpha_i;
        pix_d = !(en_i && act_r) ? '0 :
                me_alpha_i       ? me_rgb_i :
                bullet_alpha_i   ? bullet_rgb_i :
                enemy_alpha_i    ? enemy_rgb_i : bg_rgb_i;
    end
    // request registers load from the next counter values so the address shares the counter-stage cycle
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            req_x_q  <= '0;
            req_y_q  <= '0;
            for (int i = 0; i < RESP_LAT; i++) dl_q[i] <= RASTER_IDLE;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= '0;
            me_hit_q <= 1'b0;
        end else begin
            req_x_q  <= act_nxt ? h_nxt : '0;
            req_y_q  <= act_nxt ? v_nxt : '0;
            dl_q[0]  <= raster;
            for (int i = 1; i < RESP_LAT; i++) dl_q[i] <= dl_q[i-1];
            hsync_q  <= dl_q[RESP_LAT-1].hs_n;
            vsync_q  <= dl_q[RESP_LAT-1].vs_n;
            rgb_q    <= pix_d;
            me_hit_q <= me_hit_q | crash_me_enemy_o;
        end
    end
    assign req_x_addr_o = req_x_q;
    assign req_y_addr_o = req_y_q;
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign rgb_o        = rgb_q;
    assign me_hit_o     = me_hit_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: raster/compositor model checked every cycle plus hand-computed pins, on a 30-line frame
module tb_vga_scan_ctrl;
    localparam int HT = 800, HD = 640, HSB = 656, HSE = 752;
    localparam int VD = 24, VF = 2, VS = 2, TV = 30, FR = HT * TV;
    localparam int VSB = VD + VF, VSE = VSB + VS;
    logic        clk_vga = 1'b0, rst = 1'b1, en_i = 1'b1;
    logic [9:0]  req_x_addr_o, req_y_addr_o;
    logic        v_sync_o, me_alpha_i = 1'b0, bullet_alpha_i = 1'b0, enemy_alpha_i = 1'b0;
    logic [11:0] me_rgb_i = 12'hA5A, bullet_rgb_i = 12'h0F0, enemy_rgb_i = 12'hF00, bg_rgb_i = 12'h123, rgb_o;
    logic        crash_enemy_bullet_o, crash_me_enemy_o, me_hit_o, hsync_o, vsync_o;
    int          cyc = 0, n_cmp = 0, n_err = 0;
    int          hs_falls[$], vs_pulses[$], me_crash[$], eb_crash[$];
    int          vs_low[2] = '{0, 0};
    bit          hit_m = 1'b0, prev_hs = 1'b1, p_en = 1'b0, e_act, e_eb, e_me;
    logic [11:0] p_pix = '0;

    vga_scan_ctrl #(.RESP_LAT(1), .V_ACT(VD), .V_FP(VF), .V_SW(VS), .V_TOT(TV)) dut (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i),
        .req_x_addr_o(req_x_addr_o), .req_y_addr_o(req_y_addr_o), .v_sync_o(v_sync_o),
        .me_alpha_i(me_alpha_i), .me_rgb_i(me_rgb_i),
        .bullet_alpha_i(bullet_alpha_i), .bullet_rgb_i(bullet_rgb_i),
        .enemy_alpha_i(enemy_alpha_i), .enemy_rgb_i(enemy_rgb_i), .bg_rgb_i(bg_rgb_i),
        .crash_enemy_bullet_o(crash_enemy_bullet_o), .crash_me_enemy_o(crash_me_enemy_o),
        .me_hit_o(me_hit_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .rgb_o(rgb_o)
    );

    always #20 clk_vga = ~clk_vga;
    always @(posedge clk_vga) cyc <= rst ? 0 : cyc + 1;

    function automatic int h_of(input int k); return (k % FR) % HT; endfunction
    function automatic int v_of(input int k); return (k % FR) / HT; endfunction
    function automatic bit act_at(input int k); return k >= 0 && h_of(k) < HD && v_of(k) < VD; endfunction
    function automatic bit hs_at(input int k); return k < 0 || !(h_of(k) >= HSB && h_of(k) < HSE); endfunction
    function automatic bit vs_at(input int k); return k < 0 || !(v_of(k) >= VSB && v_of(k) < VSE); endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // layer model: responds in cycle n to the pixel requested in cycle n-1
    task automatic drive(input int p);
        int h, v, f;
        en_i = 1'b1;
        {me_alpha_i, bullet_alpha_i, enemy_alpha_i} = 3'b000;
        if (p >= 0) begin
            h = h_of(p); v = v_of(p); f = p / FR;
            if (f == 0 && v == 10 && h == 100) {me_alpha_i, enemy_alpha_i} = 2'b11;
            if (f == 0 && v == 5 && h >= HD) {me_alpha_i, bullet_alpha_i, enemy_alpha_i} = 3'b111;
            if (f == 0 && v == 12 && h >= 318 && h < 323) en_i = 1'b0;
            if (f == 0 && v == 12 && h == 320) {bullet_alpha_i, enemy_alpha_i} = 2'b11;
            if (f == 0 && v == 15 && h == 200) {me_alpha_i, bullet_alpha_i, enemy_alpha_i} = 3'b111;
            if (f == 1 && v == 3 && h == 50) {bullet_alpha_i, enemy_alpha_i} = 2'b11;
            if (f == 1 && v == 3 && h == 60) enemy_alpha_i = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk_vga);
        #1;
        drive(cyc - 1);
    end

    always @(negedge clk_vga) if (!rst) begin
        if (cyc == 0) begin
            hit_m = 1'b0; prev_hs = 1'b1;
            hs_falls.delete(); vs_pulses.delete(); me_crash.delete(); eb_crash.delete();
        end
        e_act = en_i && act_at(cyc - 1);
        e_eb  = e_act && enemy_alpha_i && bullet_alpha_i;
        e_me  = e_act && me_alpha_i && enemy_alpha_i;
        chk("req_x", req_x_addr_o, act_at(cyc) ? h_of(cyc) : 0);
        chk("req_y", req_y_addr_o, act_at(cyc) ? v_of(cyc) : 0);
        chk("v_sync", v_sync_o, h_of(cyc) == 0 && v_of(cyc) == VD);
        chk("crash_eb", crash_enemy_bullet_o, e_eb);
        chk("crash_me", crash_me_enemy_o, e_me);
        chk("me_hit", me_hit_o, hit_m);
        chk("hsync", hsync_o, hs_at(cyc - 2));
        chk("vsync", vsync_o, vs_at(cyc - 2));
        chk("rgb", rgb_o, (act_at(cyc - 2) && p_en) ? p_pix : 12'h000);
        hit_m |= e_me;
        p_en  = en_i;
        p_pix = me_alpha_i ? me_rgb_i : bullet_alpha_i ? bullet_rgb_i : enemy_alpha_i ? enemy_rgb_i : bg_rgb_i;
        if (v_sync_o) vs_pulses.push_back(cyc);
        if (prev_hs && !hsync_o) hs_falls.push_back(cyc);
        prev_hs = hsync_o;
        if (!vsync_o && cyc < 2 * FR) vs_low[cyc / FR]++;
        if (crash_me_enemy_o) me_crash.push_back(cyc);
        if (crash_enemy_bullet_o) eb_crash.push_back(cyc);
    end

    task automatic wait_cyc(input int t);
        int g = 0;
        @(negedge clk_vga);
        while (cyc != t && g < 200000) begin
            @(negedge clk_vga);
            g++;
        end
        if (cyc != t) begin
            n_err++;
            $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, t);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_vga);
        #1 rst = 1'b0;
        wait_cyc(0);
        chk("rst_rgb", rgb_o, 0);
        chk("rst_hsync", hsync_o, 1);
        chk("rst_vsync", vsync_o, 1);
        chk("rst_me_hit", me_hit_o, 0);
        chk("rst_v_sync", v_sync_o, 0);
        wait_cyc(7);     chk("bg_pixel", rgb_o, 12'h123);
        wait_cyc(4702);  chk("blank_alpha_pixel", rgb_o, 12'h000);
        wait_cyc(8101);  chk("crash_me_100_10", crash_me_enemy_o, 1);
        wait_cyc(8102);
        chk("me_pixel", rgb_o, 12'hA5A);
        chk("me_hit_set", me_hit_o, 1);
        chk("crash_me_one_cycle", crash_me_enemy_o, 0);
        wait_cyc(9921);  chk("crash_eb_disabled", crash_enemy_bullet_o, 0);
        wait_cyc(9922);  chk("disabled_pixel", rgb_o, 12'h000);
        wait_cyc(12201);
        chk("triple_crash_eb", crash_enemy_bullet_o, 1);
        chk("triple_crash_me", crash_me_enemy_o, 1);
        wait_cyc(12202); chk("triple_pixel", rgb_o, 12'hA5A);
        wait_cyc(26452); chk("bullet_pixel", rgb_o, 12'h0F0);
        wait_cyc(26462); chk("enemy_pixel", rgb_o, 12'hF00);
        wait_cyc(50000);
        chk("hs_fall_first", hs_falls[0], 658);
        chk("hs_fall_second", hs_falls[1], 1458);
        chk("v_sync_count", vs_pulses.size(), 2);
        chk("v_sync_first", vs_pulses[0], VD * HT);
        chk("v_sync_second", vs_pulses[1], VD * HT + FR);
        chk("vsync_low_f0", vs_low[0], 1600);
        chk("vsync_low_f1", vs_low[1], 1600);
        chk("crash_me_count", me_crash.size(), 2);
        chk("crash_me_at", me_crash[0], 8101);
        chk("crash_eb_count", eb_crash.size(), 2);
        chk("crash_eb_at", eb_crash[1], 26451);
        wait_cyc(2 * FR + 20 * HT + 399);
        chk("me_hit_before_rst", me_hit_o, 1);
        @(posedge clk_vga);
        #1 rst = 1'b1;
        @(posedge clk_vga);
        #1 rst = 1'b0;
        wait_cyc(0);
        chk("mid_rst_req_x", req_x_addr_o, 0);
        chk("mid_rst_req_y", req_y_addr_o, 0);
        chk("mid_rst_me_hit", me_hit_o, 0);
        chk("mid_rst_hsync", hsync_o, 1);
        chk("mid_rst_rgb", rgb_o, 0);
        wait_cyc(1600);
        chk("mid_rst_hs_fall_first", hs_falls[0], 658);
        chk("mid_rst_hs_fall_second", hs_falls[1], 1458);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Initiating end of the per-pixel sprite layer protocol. It scans a 640x480@60 raster on the VGA clock and issues `req_x_addr_o`/`req_y_addr_o` plus a once-per-frame `v_sync_o` strobe to the sprite layers (player, bullets, enemy group). It collects each layer's alpha/RGB response and composites them by priority into the VGA output. From the coincident alphas it also generates the per-pixel crash strobes that the layers consume.

## Interface
- `RESP_LAT`, default 1: cycles from request address to the matching layer alpha/rgb response; range 1-3.
- `clk_vga`  in  1  pixel clock, 25.175 MHz nominal.
- `rst`  in  1  synchronous, active-high reset.
- `en_i`  in  1  game running; when low, pixel output and crash strobes are forced to 0.
- `req_x_addr_o`  out  `H_DISP_LEN`  requested pixel column.
- `req_y_addr_o`  out  `V_DISP_LEN`  requested pixel row.
- `v_sync_o`  out  1  one-cycle frame strobe for layer motion update.
- `me_alpha_i` / `me_rgb_i`  in  1 / `COLOR_RGB_DEPTH`  player layer response.
- `bullet_alpha_i` / `bullet_rgb_i`  in  1 / `COLOR_RGB_DEPTH`  bullet layer response.
- `enemy_alpha_i` / `enemy_rgb_i`  in  1 / `COLOR_RGB_DEPTH`  enemy layer response.
- `bg_rgb_i`  in  `COLOR_RGB_DEPTH`  background colour, always opaque.
- `crash_enemy_bullet_o`  out  1  bullet overlaps enemy at the current response pixel.
- `crash_me_enemy_o`  out  1  player overlaps enemy at the current response pixel.
- `me_hit_o`  out  1  sticky; set by any `crash_me_enemy_o`.
- `hsync_o`, `vsync_o`  out  1  VGA syncs, active low.
- `rgb_o`  out  `COLOR_RGB_DEPTH`  pixel to DAC.

## Operation
- Counters:
  - `h_cnt` runs 0..799 and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps, runs 0..524 and wraps to 0.
  - Both counters run regardless of `en_i`.
- Raw timing, counter stage:
  - `act` = (h_cnt<640)&&(v_cnt<480).
  - `hs_n` low for h_cnt in [656,752).
  - `vs_n` low for v_cnt in [490,492).
- Requests:
  - When `act`=1: `req_x_addr_o`=h_cnt and `req_y_addr_o`=v_cnt, both registered at the counter stage.
  - When `act`=0: both are 0.
- `v_sync_o`: 1 for exactly the cycle where the counter stage is at h_cnt=0, v_cnt=480. One pulse per 420000 cycles.
- `act`, `hs_n` and `vs_n` pass through a `RESP_LAT`-deep delay line to align them with the layer responses. The delayed active flag is `act_r`.
- Composition, registered:
  - `rgb_o` = 0 if !act_r or !en_i.
  - Otherwise priority is me > bullet > enemy > bg.
  - `hsync_o`/`vsync_o` get one more register stage so they stay aligned with `rgb_o`.
- Crash strobes are combinational from the current inputs, so each layer can AND them with its own alpha in the same cycle:
  - `crash_enemy_bullet_o` = en_i & act_r & enemy_alpha_i & bullet_alpha_i.
  - `crash_me_enemy_o` = en_i & act_r & me_alpha_i & enemy_alpha_i.
- `me_hit_o`: set on the edge after `crash_me_enemy_o`=1; cleared only by `rst`.
- Simultaneous me+bullet+enemy alpha:
  - Both strobes assert.
  - `rgb_o` shows `me_rgb_i`.
- `en_i` toggling mid-frame takes effect on the next cycle. There is no frame realignment.

## Timing
- Reset values:
  - h_cnt=v_cnt=0.
  - req addrs 0.
  - `v_sync_o`=0.
  - `hsync_o`=`vsync_o`=1.
  - `rgb_o`=0.
  - `me_hit_o`=0.
  - Delay lines cleared to inactive (act 0, syncs 1).
- Reset taken mid-frame: all of the above hold on the edge after `rst` is sampled high; no partial line is completed.
- Request-to-pixel latency:
  - Pixel (x,y) is requested at cycle T.
  - Its response is sampled at T+`RESP_LAT`; the crash strobes are valid in that cycle.
  - `rgb_o` is valid at T+`RESP_LAT`+1.
- First `hsync_o` fall after reset release: edge 656+`RESP_LAT`+1. Subsequent falls every 800 cycles.
- Layer inputs are assumed stable only in their response cycle. The block samples them on exactly that edge.

## Structure
- Constants added to `define.v`: `H_DISP` 640, `H_FRONT` 16, `H_SYNC` 96, `H_TOTAL` 800, `V_DISP` 480, `V_FRONT` 10, `V_SYNC` 2, `V_TOTAL` 525.
- Existing `H_DISP_LEN`, `V_DISP_LEN` and `COLOR_RGB_DEPTH` widths are reused.
- One sub-module: `vga_timing_gen`. It holds the counters, raw act/hs/vs and the `v_sync_o` strobe.
- `vga_scan_ctrl` holds the request registers, delay lines, compositor and crash logic.

## Test plan
- Reset release, all alphas 0, `bg_rgb_i`=12'h123:
  - `hsync_o` falls at cycle 658 (`RESP_LAT`=1), then every 800 cycles.
  - `rgb_o`=12'h123 inside active area and 0 in blanking.
- Run two frames:
  - `v_sync_o` pulses exactly twice, 420000 cycles apart, each in the cycle `req` stage is at (0,480).
  - `vsync_o` is low for 1600 cycles per frame.
- Layer model returns `me_alpha_i`=`enemy_alpha_i`=1 for request (100,200):
  - `crash_me_enemy_o`=1 in the response cycle only.
  - `rgb_o`=`me_rgb_i` next cycle.
  - `me_hit_o`=1 from then on.
- All alphas forced 1 during h_cnt in [640,800):
  - No crash strobe.
  - `rgb_o`=0.
- `en_i`=0 with bullet+enemy overlap at (320,240):
  - `crash_enemy_bullet_o`=0 and `rgb_o`=0.
  - Counters/`hsync_o` period unchanged.
- Assert `rst` for one cycle at h_cnt=400, v_cnt=300 after `me_hit_o`=1:
  - Next cycle counters read 0,0 and `me_hit_o`=0.
  - Sync timing restarts as in the first scenario.
